// File: rtl/cov_tlb_tracker_pkg.sv
// Shared definitions for the TLB coverage tracker.
//   tlb_tag_t        : one TLB entry tag. Fields are sized to the largest
//                      supported geometry; narrower tags are zero-extended.
//   tlb_trk_state_e  : tracker FSM encoding (IDLE / TRACK / FLUSH_WAIT)
//   tag_match()      : tag equality with page-size VPN masking
package cov_core_defs;

    localparam int unsigned MAX_ASID_W = 32;
    localparam int unsigned MAX_LEVELS = 5;
    localparam int unsigned MAX_SEG_W  = 16;

    typedef struct packed {
        logic [MAX_ASID_W-1:0]                asid;
        logic [MAX_LEVELS-1:0][MAX_SEG_W-1:0] vpn;
        logic                                 is_2M;
        logic                                 is_1G;
        logic                                 valid;
    } tlb_tag_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRACK      = 2'd1,
        FLUSH_WAIT = 2'd2
    } tlb_trk_state_e;

    // Only the top segment is significant for a 1G page, the top two for 2M.
    // Segments at or above 'levels' are zero in both tags and are skipped.
    function automatic logic tag_match(input tlb_tag_t a, input tlb_tag_t b,
                                       input int unsigned levels);
        logic        m;
        int unsigned keep_from;
        keep_from = 0;
        if (a.is_1G && levels >= 1)
            keep_from = levels - 1;
        else if (a.is_2M && levels >= 2)
            keep_from = levels - 2;
        m = a.valid && b.valid && (a.asid == b.asid) &&
            (a.is_1G == b.is_1G) && (a.is_2M == b.is_2M);
        for (int unsigned s = 0; s < MAX_LEVELS; s++) begin
            if (s >= keep_from && s < levels && a.vpn[s] != b.vpn[s])
                m = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/cov_sat_counter.sv
// Saturating up-counter with a multi-bit increment.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clear : synchronous clear, wins over a same-cycle increment
//   inc   : amount added this cycle
//   count : current value, holds at all-ones instead of wrapping
module cov_sat_counter #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] limit;

    always_comb begin
        sum   = SUM_W'(count) + SUM_W'(inc);
        limit = SUM_W'({CNT_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (sum > limit)
            count <= '1;
        else
            count <= sum[CNT_W-1:0];
    end

endmodule

// File: rtl/cov_tlb_tracker.sv
// TLB coverage tracker: snapshots the tag array, classifies per-entry
// fill/evict/replace events, counts lookups and miss bursts, checks flush
// completion and duplicate valid tags, and reports occupancy statistics.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   sample_en_i, clear_i     : tracking enable, zero counters and sticky flags
//   valid_i/is_1G_i/is_2M_i  : per-entry valid and page-size flags
//   asid_i, vpn_i            : packed per-entry ASIDs / VPN segments
//   lookup_valid_i/hit_i     : lookup completion and result
//   flush_i                  : flush request pulse
//   *_cnt_o                  : saturating event counters
//   occupancy_o, max_occupancy_o, full_seen_o : occupancy statistics
//   dup_err_o, flush_err_o   : sticky error flags
//   state_o                  : FSM state
module cov_tlb_tracker
    import cov_core_defs::*;
#(
    parameter int unsigned TLB_ENTRIES   = 16,
    parameter int unsigned ASID_WIDTH    = 16,
    parameter int unsigned VPN_LEVELS    = 3,
    parameter int unsigned VPN_SEG_W     = 9,
    parameter int unsigned WINDOW_SIZE   = 5,
    parameter int unsigned FLUSH_TIMEOUT = 8,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       sample_en_i,
    input  logic                                       clear_i,
    input  logic [TLB_ENTRIES-1:0]                     valid_i,
    input  logic [TLB_ENTRIES-1:0]                     is_1G_i,
    input  logic [TLB_ENTRIES-1:0]                     is_2M_i,
    input  logic [TLB_ENTRIES*ASID_WIDTH-1:0]          asid_i,
    input  logic [TLB_ENTRIES*VPN_LEVELS*VPN_SEG_W-1:0] vpn_i,
    input  logic                                       lookup_valid_i,
    input  logic                                       lookup_hit_i,
    input  logic                                       flush_i,
    output logic [CNT_W-1:0]                           fill_cnt_o,
    output logic [CNT_W-1:0]                           evict_cnt_o,
    output logic [CNT_W-1:0]                           replace_cnt_o,
    output logic [CNT_W-1:0]                           hit_cnt_o,
    output logic [CNT_W-1:0]                           miss_cnt_o,
    output logic [CNT_W-1:0]                           miss_burst_cnt_o,
    output logic [$clog2(TLB_ENTRIES+1)-1:0]           occupancy_o,
    output logic [$clog2(TLB_ENTRIES+1)-1:0]           max_occupancy_o,
    output logic                                       full_seen_o,
    output logic                                       dup_err_o,
    output logic                                       flush_err_o,
    output logic [1:0]                                 state_o
);

    localparam int unsigned OCC_W = $clog2(TLB_ENTRIES + 1);
    localparam int unsigned VPN_W = VPN_LEVELS * VPN_SEG_W;
    localparam int unsigned TMR_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    function automatic logic [OCC_W-1:0] popcnt(input logic [TLB_ENTRIES-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < TLB_ENTRIES; i++)
            n = n + OCC_W'(v[i]);
        return n;
    endfunction

    tlb_trk_state_e state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic             flush_timeout;

    logic [TLB_ENTRIES-1:0]            snap_valid, snap_1g, snap_2m;
    logic [TLB_ENTRIES*ASID_WIDTH-1:0] snap_asid;
    logic [TLB_ENTRIES*VPN_W-1:0]      snap_vpn;

    logic [TLB_ENTRIES-1:0] changed, fill_v, evict_v, replace_v;
    logic                   counting, lookup_en, hit_inc, miss_inc, burst_inc;
    logic [WINDOW_SIZE-1:0] miss_win, miss_win_shift;
    tlb_tag_t               cur_tag [TLB_ENTRIES];
    logic                   dup_any;

    // FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        flush_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (sample_en_i)
                    state_next = TRACK;
            end
            TRACK: begin
                if (!sample_en_i) begin
                    state_next = IDLE;
                end else if (flush_i) begin
                    state_next = FLUSH_WAIT;
                    timer_next = '0;
                end
            end
            FLUSH_WAIT: begin
                // Timer never exceeds FLUSH_TIMEOUT, so an all-clear here is
                // always within the allowed window.
                if (!sample_en_i) begin
                    state_next = IDLE;
                end else if (flush_i) begin
                    timer_next = '0;
                end else if (valid_i == '0) begin
                    state_next = TRACK;
                end else if (timer >= TMR_W'(FLUSH_TIMEOUT)) begin
                    state_next    = TRACK;
                    flush_timeout = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_o = state;

    // Snapshot of the tag array
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_valid <= '0;
            snap_1g    <= '0;
            snap_2m    <= '0;
            snap_asid  <= '0;
            snap_vpn   <= '0;
        end else if (sample_en_i) begin
            snap_valid <= valid_i;
            snap_1g    <= is_1G_i;
            snap_2m    <= is_2M_i;
            snap_asid  <= asid_i;
            snap_vpn   <= vpn_i;
        end
    end

    // Per-entry events; a replace also contributes one fill and one evict
    always_comb begin
        changed = '0;
        for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            changed[e] = (asid_i[e*ASID_WIDTH +: ASID_WIDTH] != snap_asid[e*ASID_WIDTH +: ASID_WIDTH]) ||
                         (vpn_i[e*VPN_W +: VPN_W] != snap_vpn[e*VPN_W +: VPN_W]) ||
                         (is_1G_i[e] != snap_1g[e]) || (is_2M_i[e] != snap_2m[e]);
        end
        counting  = sample_en_i && (state == TRACK || state == FLUSH_WAIT);
        replace_v = counting ? (snap_valid & valid_i & changed) : '0;
        fill_v    = counting ? ((~snap_valid & valid_i) | replace_v) : '0;
        evict_v   = replace_v;
        if (counting && state == TRACK)
            evict_v = evict_v | (snap_valid & ~valid_i);
    end

    // Lookups and miss window
    always_comb begin
        lookup_en      = lookup_valid_i && (state == TRACK || state == FLUSH_WAIT);
        hit_inc        = lookup_en && lookup_hit_i;
        miss_inc       = lookup_en && !lookup_hit_i;
        miss_win_shift = (miss_win << 1) | WINDOW_SIZE'(1);
        burst_inc      = miss_inc && (miss_win_shift == '1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i)
            miss_win <= '0;
        else if (hit_inc)
            miss_win <= '0;
        else if (miss_inc)
            miss_win <= miss_win_shift;
    end

    // Duplicate-tag detection over all entry pairs
    always_comb begin
        for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            cur_tag[e]       = '0;
            cur_tag[e].valid = valid_i[e];
            cur_tag[e].is_1G = is_1G_i[e];
            cur_tag[e].is_2M = is_2M_i[e];
            cur_tag[e].asid  = MAX_ASID_W'(asid_i[e*ASID_WIDTH +: ASID_WIDTH]);
            for (int unsigned s = 0; s < VPN_LEVELS; s++)
                cur_tag[e].vpn[s] = MAX_SEG_W'(vpn_i[(e*VPN_LEVELS+s)*VPN_SEG_W +: VPN_SEG_W]);
        end
        dup_any = 1'b0;
        for (int unsigned i = 0; i < TLB_ENTRIES; i++)
            for (int unsigned j = i + 1; j < TLB_ENTRIES; j++)
                if (tag_match(cur_tag[i], cur_tag[j], VPN_LEVELS))
                    dup_any = 1'b1;
    end

    // Occupancy and sticky flags
    always_ff @(posedge clk_i) begin
        if (rst_i)
            occupancy_o <= '0;
        else if (sample_en_i)
            occupancy_o <= popcnt(valid_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            max_occupancy_o <= '0;
            full_seen_o     <= 1'b0;
            dup_err_o       <= 1'b0;
            flush_err_o     <= 1'b0;
        end else begin
            if (occupancy_o > max_occupancy_o)
                max_occupancy_o <= occupancy_o;
            if (occupancy_o == OCC_W'(TLB_ENTRIES))
                full_seen_o <= 1'b1;
            if (state == TRACK && dup_any)
                dup_err_o <= 1'b1;
            if (flush_timeout)
                flush_err_o <= 1'b1;
        end
    end

    // Counters
    cov_sat_counter #(.CNT_W(CNT_W), .INC_W(OCC_W)) u_fill_cnt (
        .clk(clk_i), .rst(rst_i), .clear(clear_i), .inc(popcnt(fill_v)), .count(fill_cnt_o));
    cov_sat_counter #(.CNT_W(CNT_W), .INC_W(OCC_W)) u_evict_cnt (
        .clk(clk_i), .rst(rst_i), .clear(clear_i), .inc(popcnt(evict_v)), .count(evict_cnt_o));
    cov_sat_counter #(.CNT_W(CNT_W), .INC_W(OCC_W)) u_replace_cnt (
        .clk(clk_i), .rst(rst_i), .clear(clear_i), .inc(popcnt(replace_v)), .count(replace_cnt_o));
    cov_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_hit_cnt (
        .clk(clk_i), .rst(rst_i), .clear(clear_i), .inc(hit_inc), .count(hit_cnt_o));
    cov_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_miss_cnt (
        .clk(clk_i), .rst(rst_i), .clear(clear_i), .inc(miss_inc), .count(miss_cnt_o));
    cov_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_burst_cnt (
        .clk(clk_i), .rst(rst_i), .clear(clear_i), .inc(burst_inc), .count(miss_burst_cnt_o));

endmodule

// File: tb/tb_cov_tlb_tracker.sv
module tb_cov_tlb_tracker;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned L  = 3;
    localparam int unsigned SW = 9;

    logic clk = 1'b0;
    logic rst, sample_en, clear, lookup_valid, lookup_hit, flush;
    logic [N-1:0]      valid, is_1g, is_2m;
    logic [N*AW-1:0]   asid;
    logic [N*L*SW-1:0] vpn;

    logic [31:0] fill_cnt, evict_cnt, replace_cnt, hit_cnt, miss_cnt, burst_cnt;
    logic [4:0]  occ, max_occ;
    logic        full_seen, dup_err, flush_err;
    logic [1:0]  state;

    logic [3:0]  f4, e4, r4, h4, m4, b4;
    logic [4:0]  occ4, max4;
    logic        full4, dup4, ferr4;
    logic [1:0]  state4;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cov_tlb_tracker dut (
        .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .clear_i(clear),
        .valid_i(valid), .is_1G_i(is_1g), .is_2M_i(is_2m), .asid_i(asid), .vpn_i(vpn),
        .lookup_valid_i(lookup_valid), .lookup_hit_i(lookup_hit), .flush_i(flush),
        .fill_cnt_o(fill_cnt), .evict_cnt_o(evict_cnt), .replace_cnt_o(replace_cnt),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .miss_burst_cnt_o(burst_cnt),
        .occupancy_o(occ), .max_occupancy_o(max_occ), .full_seen_o(full_seen),
        .dup_err_o(dup_err), .flush_err_o(flush_err), .state_o(state));

    cov_tlb_tracker #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .clear_i(clear),
        .valid_i(valid), .is_1G_i(is_1g), .is_2M_i(is_2m), .asid_i(asid), .vpn_i(vpn),
        .lookup_valid_i(lookup_valid), .lookup_hit_i(lookup_hit), .flush_i(flush),
        .fill_cnt_o(f4), .evict_cnt_o(e4), .replace_cnt_o(r4),
        .hit_cnt_o(h4), .miss_cnt_o(m4), .miss_burst_cnt_o(b4),
        .occupancy_o(occ4), .max_occupancy_o(max4), .full_seen_o(full4),
        .dup_err_o(dup4), .flush_err_o(ferr4), .state_o(state4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int unsigned idx, input logic v, input logic [15:0] a,
                             input logic g1, input logic [8:0] s0, input logic [8:0] s1,
                             input logic [8:0] s2);
        valid[idx] = v;
        is_1g[idx] = g1;
        asid[idx*AW +: AW] = a;
        vpn[(idx*L+0)*SW +: SW] = s0;
        vpn[(idx*L+1)*SW +: SW] = s1;
        vpn[(idx*L+2)*SW +: SW] = s2;
    endtask

    task automatic lookup(input logic hit);
        lookup_valid = 1'b1;
        lookup_hit   = hit;
        tick();
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        tick(); tick();
        rst = 1'b0;
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state, e); end
        e = exp_q.pop_front(); n_cmp++; if (fill_cnt !== e) begin n_fail++; $display("FAIL reset_fill got=%0d exp=%0d", fill_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (occ !== e[4:0]) begin n_fail++; $display("FAIL reset_occ got=%0d exp=%0d", occ, e); end
        e = exp_q.pop_front(); n_cmp++; if (dup_err !== e[0]) begin n_fail++; $display("FAIL reset_dup got=%0d exp=%0d", dup_err, e); end
        e = exp_q.pop_front(); n_cmp++; if (flush_err !== e[0]) begin n_fail++; $display("FAIL reset_flush_err got=%0d exp=%0d", flush_err, e); end
    endtask

    task automatic test_fill();
        sample_en = 1'b1;
        exp_q.push_back(32'd1);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL idle_to_track got=%0d exp=%0d", state, e); end
        for (int unsigned i = 0; i < 4; i++) begin
            set_entry(i, 1'b1, (i == 2) ? 16'd5 : 16'(10 + i), 1'b0, 9'(i), 9'(i), 9'(i));
            tick();
        end
        exp_q.push_back(32'd4); exp_q.push_back(32'd4); exp_q.push_back(32'd4);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (fill_cnt !== e) begin n_fail++; $display("FAIL fill_cnt got=%0d exp=%0d", fill_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (occ !== e[4:0]) begin n_fail++; $display("FAIL occupancy got=%0d exp=%0d", occ, e); end
        e = exp_q.pop_front(); n_cmp++; if (max_occ !== e[4:0]) begin n_fail++; $display("FAIL max_occ got=%0d exp=%0d", max_occ, e); end
    endtask

    task automatic test_replace_evict();
        asid[2*AW +: AW] = 16'd7;
        valid[3] = 1'b0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd5);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (replace_cnt !== e) begin n_fail++; $display("FAIL replace_cnt got=%0d exp=%0d", replace_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (evict_cnt !== e) begin n_fail++; $display("FAIL evict_cnt got=%0d exp=%0d", evict_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (fill_cnt !== e) begin n_fail++; $display("FAIL fill_after_replace got=%0d exp=%0d", fill_cnt, e); end
    endtask

    task automatic test_flush_ok();
        flush = 1'b1;
        exp_q.push_back(32'd2);
        tick();
        flush = 1'b0;
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL flush_wait_state got=%0d exp=%0d", state, e); end
        tick(); tick();
        valid = '0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL flush_done_state got=%0d exp=%0d", state, e); end
        e = exp_q.pop_front(); n_cmp++; if (evict_cnt !== e) begin n_fail++; $display("FAIL flush_no_evict got=%0d exp=%0d", evict_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (flush_err !== e[0]) begin n_fail++; $display("FAIL flush_ok_err got=%0d exp=%0d", flush_err, e); end
    endtask

    task automatic test_flush_timeout();
        valid[0] = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL timeout_pre_state got=%0d exp=%0d", state, e); end
        e = exp_q.pop_front(); n_cmp++; if (flush_err !== e[0]) begin n_fail++; $display("FAIL timeout_pre_err got=%0d exp=%0d", flush_err, e); end
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL timeout_state got=%0d exp=%0d", state, e); end
        e = exp_q.pop_front(); n_cmp++; if (flush_err !== e[0]) begin n_fail++; $display("FAIL timeout_err got=%0d exp=%0d", flush_err, e); end
        tick();
        valid[0] = 1'b0;
        exp_q.push_back(32'd3); exp_q.push_back(32'd6);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (evict_cnt !== e) begin n_fail++; $display("FAIL track_evict got=%0d exp=%0d", evict_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (fill_cnt !== e) begin n_fail++; $display("FAIL refill got=%0d exp=%0d", fill_cnt, e); end
    endtask

    task automatic test_lookup();
        repeat (5) lookup(1'b0);
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); n_cmp++; if (burst_cnt !== e) begin n_fail++; $display("FAIL first_burst got=%0d exp=%0d", burst_cnt, e); end
        lookup(1'b0);
        lookup(1'b1);
        lookup(1'b0);
        exp_q.push_back(32'd7); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
        e = exp_q.pop_front(); n_cmp++; if (miss_cnt !== e) begin n_fail++; $display("FAIL miss_cnt got=%0d exp=%0d", miss_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (hit_cnt !== e) begin n_fail++; $display("FAIL hit_cnt got=%0d exp=%0d", hit_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (burst_cnt !== e) begin n_fail++; $display("FAIL burst_cnt got=%0d exp=%0d", burst_cnt, e); end
    endtask

    task automatic test_dup();
        set_entry(0, 1'b1, 16'd1, 1'b0, 9'd1, 9'd3, 9'h55);
        set_entry(5, 1'b1, 16'd1, 1'b0, 9'd2, 9'd4, 9'h55);
        exp_q.push_back(32'd0);
        tick(); tick();
        e = exp_q.pop_front(); n_cmp++; if (dup_err !== e[0]) begin n_fail++; $display("FAIL dup_4k got=%0d exp=%0d", dup_err, e); end
        is_1g[0] = 1'b1;
        is_1g[5] = 1'b1;
        exp_q.push_back(32'd1);
        tick();
        e = exp_q.pop_front(); n_cmp++; if (dup_err !== e[0]) begin n_fail++; $display("FAIL dup_1g got=%0d exp=%0d", dup_err, e); end
    endtask

    task automatic test_full();
        for (int unsigned i = 0; i < N; i++)
            set_entry(i, 1'b1, 16'(100 + i), 1'b0, 9'(i), 9'(i), 9'(i));
        exp_q.push_back(32'd16); exp_q.push_back(32'd1); exp_q.push_back(32'd16);
        tick(); tick();
        e = exp_q.pop_front(); n_cmp++; if (occ !== e[4:0]) begin n_fail++; $display("FAIL full_occ got=%0d exp=%0d", occ, e); end
        e = exp_q.pop_front(); n_cmp++; if (full_seen !== e[0]) begin n_fail++; $display("FAIL full_seen got=%0d exp=%0d", full_seen, e); end
        e = exp_q.pop_front(); n_cmp++; if (max_occ !== e[4:0]) begin n_fail++; $display("FAIL full_max got=%0d exp=%0d", max_occ, e); end
    endtask

    task automatic test_saturation();
        repeat (20) lookup(1'b1);
        exp_q.push_back(32'd15); exp_q.push_back(32'd21);
        e = exp_q.pop_front(); n_cmp++; if (h4 !== e[3:0]) begin n_fail++; $display("FAIL sat_hit4 got=%0d exp=%0d", h4, e); end
        e = exp_q.pop_front(); n_cmp++; if (hit_cnt !== e) begin n_fail++; $display("FAIL hit32 got=%0d exp=%0d", hit_cnt, e); end
        clear = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        lookup(1'b1);
        clear = 1'b0;
        e = exp_q.pop_front(); n_cmp++; if (h4 !== e[3:0]) begin n_fail++; $display("FAIL clear_hit4 got=%0d exp=%0d", h4, e); end
        e = exp_q.pop_front(); n_cmp++; if (hit_cnt !== e) begin n_fail++; $display("FAIL clear_hit got=%0d exp=%0d", hit_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (miss_cnt !== e) begin n_fail++; $display("FAIL clear_miss got=%0d exp=%0d", miss_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (full_seen !== e[0]) begin n_fail++; $display("FAIL clear_full got=%0d exp=%0d", full_seen, e); end
    endtask

    task automatic test_reset_mid_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        tick();
        rst = 1'b0;
        e = exp_q.pop_front(); n_cmp++; if (state !== e[1:0]) begin n_fail++; $display("FAIL rst_flush_state got=%0d exp=%0d", state, e); end
        e = exp_q.pop_front(); n_cmp++; if (flush_err !== e[0]) begin n_fail++; $display("FAIL rst_flush_err got=%0d exp=%0d", flush_err, e); end
        e = exp_q.pop_front(); n_cmp++; if (fill_cnt !== e) begin n_fail++; $display("FAIL rst_flush_fill got=%0d exp=%0d", fill_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (occ !== e[4:0]) begin n_fail++; $display("FAIL rst_flush_occ got=%0d exp=%0d", occ, e); end
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; clear = 1'b0; flush = 1'b0;
        lookup_valid = 1'b0; lookup_hit = 1'b0;
        valid = '0; is_1g = '0; is_2m = '0; asid = '0; vpn = '0;
        test_reset();
        test_fill();
        test_replace_evict();
        test_flush_ok();
        test_flush_timeout();
        test_lookup();
        test_dup();
        test_full();
        test_saturation();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cov_tlb_tracker.md
Name: cov_tlb_tracker

Overview:
- Parametrised TLB coverage tracker for the manycore verification environment; instantiated per core per TLB (ITLB/DTLB, any depth).
- Snapshots the TLB tag array every enabled cycle and classifies per-entry transitions as fill, evict, replace or flush-clear.
- Counts lookup hit/miss, detects miss bursts over a sliding window, checks flush completion and duplicate valid tags.
- Reports occupancy statistics and saturating counters to coverage collection.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (>=2)
ASID_WIDTH, 16, ASID bits per entry
VPN_LEVELS, 3, page-table levels (VPN segments per tag)
VPN_SEG_W, 9, bits per VPN segment
WINDOW_SIZE, 5, consecutive-miss window length (>=1)
FLUSH_TIMEOUT, 8, cycles allowed for all valids to clear after flush
CNT_W, 32, counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
sample_en_i  in  1  tracking enable
clear_i  in  1  zero counters and sticky flags
valid_i  in  TLB_ENTRIES  entry valid bits
is_1G_i  in  TLB_ENTRIES  1G page flags
is_2M_i  in  TLB_ENTRIES  2M page flags
asid_i  in  TLB_ENTRIES*ASID_WIDTH  entry ASIDs, entry 0 in LSBs
vpn_i  in  TLB_ENTRIES*VPN_LEVELS*VPN_SEG_W  entry VPNs, segment 0 in LSBs
lookup_valid_i  in  1  lookup completed this cycle
lookup_hit_i  in  1  lookup result
flush_i  in  1  flush request pulse
fill_cnt_o  out  CNT_W  fills
evict_cnt_o  out  CNT_W  evictions without flush
replace_cnt_o  out  CNT_W  tag changes on a still-valid entry
hit_cnt_o  out  CNT_W  lookup hits
miss_cnt_o  out  CNT_W  lookup misses
miss_burst_cnt_o  out  CNT_W  windows of WINDOW_SIZE consecutive misses
occupancy_o  out  $clog2(TLB_ENTRIES+1)  registered valid popcount
max_occupancy_o  out  $clog2(TLB_ENTRIES+1)  peak occupancy
full_seen_o  out  1  sticky: occupancy reached TLB_ENTRIES
dup_err_o  out  1  sticky: two valid entries with equal tag
flush_err_o  out  1  sticky: flush timeout
state_o  out  2  FSM state

Behaviour:
- Reset: all outputs 0; snapshot regs 0; FSM IDLE. Reset mid-flush aborts without setting flush_err_o.
- Tag equality: valid, same ASID, same page size, VPN segments compared except those masked by size (1G: only the top segment; 2M: top two segments).
- FSM: IDLE -> TRACK when sample_en_i=1 (the snapshot loads on this cycle; no events counted). TRACK -> IDLE when sample_en_i=0. TRACK -> FLUSH_WAIT on flush_i; the timer loads 0. FLUSH_WAIT -> TRACK when all valid_i=0 while timer <= FLUSH_TIMEOUT. FLUSH_WAIT -> TRACK with flush_err_o=1 when the timer would exceed FLUSH_TIMEOUT. flush_i in FLUSH_WAIT restarts the timer. sample_en_i=0 in FLUSH_WAIT returns to IDLE and sets no error.
- Per-entry events in TRACK vs snapshot (1-cycle latency to counters):
  - 0->1 = fill.
  - 1->0 = evict.
  - 1->1 with changed ASID/VPN/size = replace, also counted as 1 evict + 1 fill.
  - Counters add the popcount of the event vectors in the same cycle.
  - In FLUSH_WAIT, 1->0 is not counted as evict; fills are still counted.
- Snapshot updates every cycle sample_en_i=1.
- Lookups counted in TRACK and FLUSH_WAIT.
- Miss window: WINDOW_SIZE-bit shift register of miss flags, shifted on lookup_valid_i. miss_burst_cnt increments on each lookup after which all bits are 1 (overlapping runs count). The shift register clears on a hit and on clear_i.
- All counters saturate at 2^CNT_W-1, with no wrap.
- occupancy_o registered each cycle sample_en_i=1. max_occupancy_o and full_seen_o update from it.
- Duplicate check: all pairs i<j, registered; dup_err_o sticky. Checked in TRACK only.
- clear_i has priority over same-cycle increments. It does not change FSM state or the snapshot.

Decomposition:
- Shared package cov_core_defs:
  - tlb_tag_t struct (asid, vpn array, is_2M, is_1G, valid) parametrised by the widths above.
  - tlb_trk_state_e enum: IDLE=0, TRACK=1, FLUSH_WAIT=2.
  - tag_match function applying the page-size mask.
- One sub-module: cov_sat_counter (CNT_W, increment amount input, clear, saturation), instantiated six times.

Test Plan:
- Reset, then sample_en_i=1; set entries 0..3 valid over 4 cycles -> fill_cnt_o=4, occupancy_o=4, max_occupancy_o=4.
- Entry 2 ASID changes 5->7 while valid, entry 3 valid drops -> replace_cnt_o=1, evict_cnt_o=2, fill_cnt_o=5.
- flush_i, all valids cleared 3 cycles later -> state FLUSH_WAIT then TRACK, evict_cnt_o unchanged, flush_err_o=0. Repeat with valids held for 10 cycles -> flush_err_o=1 after cycle 9.
- Lookups M,M,M,M,M,M,H,M (WINDOW_SIZE=5) -> miss_cnt_o=7, hit_cnt_o=1, miss_burst_cnt_o=2.
- Entries 0 and 5 both valid with ASID 1, is_1G=1, equal top segment, differing lower segments -> dup_err_o=1 one cycle later; same case with is_1G=0 -> dup_err_o stays 0.
- CNT_W=4, 20 hits -> hit_cnt_o=15. clear_i with a simultaneous hit -> hit_cnt_o=0.
